// File: rtl/d_mem_arb.sv
// d_mem_arb: shares the single d_mem port between the core Q103H data access
// and one MMIO requester. The core has priority. MMIO is served when the core
// is idle. It is also served after waiting STARVE_MAX cycles, by stalling the
// core for one cycle. Memory read data returns one cycle after MemRd.
//
// Handshakes (valid/ready):
// - A request transfers in a cycle where MmioReqValid && MmioReqReady.
//   MmioReqReady is combinational and only rises in IDLE.
// - The response is held stable while MmioRspValid is high. It completes in
//   the cycle where MmioRspValid && MmioRspReady.
// - Only one MMIO transaction is outstanding at a time.
module d_mem_arb #(
  parameter int STARVE_MAX   = 8,
  parameter int STARVE_CNT_W = 4
) (
  input  logic                    QClk,
  input  logic                    RstQnnnL,
  input  logic [31:0]             CoreAdrsQ103H,
  input  logic [31:0]             CoreWrDataQ103H,
  input  logic [3:0]              CoreByteEnQ103H,
  input  logic                    CoreWrQ103H,
  input  logic                    CoreRdQ103H,
  output logic                    CoreStallQ103H,
  output logic [31:0]             CoreRdDataQ104H,
  input  logic                    MmioReqValid,
  output logic                    MmioReqReady,
  input  logic                    MmioReqWr,
  input  logic [31:0]             MmioReqAdrs,
  input  logic [31:0]             MmioReqData,
  input  logic [3:0]              MmioReqByteEn,
  output logic                    MmioRspValid,
  input  logic                    MmioRspReady,
  output logic [31:0]             MmioRspData,
  output logic [31:0]             MemAdrs,
  output logic [31:0]             MemWrData,
  output logic [3:0]              MemByteEn,
  output logic                    MemRd,
  output logic                    MemWr,
  input  logic [31:0]             MemRdData,
  output logic [1:0]              DbgState,
  output logic [STARVE_CNT_W-1:0] DbgStarveCnt
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    RSP     = 2'd2
  } arbState_t;

  arbState_t               state, stateNext;
  logic [STARVE_CNT_W-1:0] starveCnt;
  logic [31:0]             rspDataReg;
  logic                    coreRdQ;
  logic                    coreReq;
  logic                    starveHit;
  logic                    isIdle;
  logic                    coreRdIssue;

  assign coreReq   = CoreRdQ103H | CoreWrQ103H;
  assign starveHit = (starveCnt == STARVE_CNT_W'(STARVE_MAX));
  assign isIdle    = (state == IDLE);

  assign MmioReqReady   = isIdle & MmioReqValid & (~coreReq | starveHit);
  assign CoreStallQ103H = isIdle & MmioReqValid & coreReq & starveHit;

  // A core read reaches memory only when MMIO does not own the port this
  // cycle. A simultaneous write takes precedence over the read.
  assign coreRdIssue = ~MmioReqReady & ~CoreStallQ103H & CoreRdQ103H & ~CoreWrQ103H;

  // Memory port mux: an accepted MMIO request, else an unstalled core access, else idle.
  always_comb begin
    MemAdrs   = '0;
    MemWrData = '0;
    MemByteEn = '0;
    MemRd     = 1'b0;
    MemWr     = 1'b0;
    if (MmioReqReady) begin
      MemAdrs   = MmioReqAdrs;
      MemWrData = MmioReqData;
      MemByteEn = MmioReqByteEn;
      MemRd     = ~MmioReqWr;
      MemWr     = MmioReqWr;
    end else if (coreReq && !CoreStallQ103H) begin
      MemAdrs   = CoreAdrsQ103H;
      MemWrData = CoreWrDataQ103H;
      MemByteEn = CoreByteEnQ103H;
      MemRd     = CoreRdQ103H & ~CoreWrQ103H;
      MemWr     = CoreWrQ103H;
    end
  end

  // Remember whether the returning read data belongs to the core.
  always_ff @(posedge QClk or negedge RstQnnnL) begin
    if (!RstQnnnL) coreRdQ <= 1'b0;
    else           coreRdQ <= coreRdIssue;
  end

  assign CoreRdDataQ104H = coreRdQ ? MemRdData : 32'h0;

  // Starvation counter: count waiting MMIO cycles in IDLE, and hold while a transaction is in flight.
  always_ff @(posedge QClk or negedge RstQnnnL) begin
    if (!RstQnnnL) begin
      starveCnt <= '0;
    end else if (isIdle) begin
      if (MmioReqReady || !MmioReqValid) starveCnt <= '0;
      else if (!starveHit)               starveCnt <= starveCnt + STARVE_CNT_W'(1);
    end
  end

  // FSM state register.
  always_ff @(posedge QClk or negedge RstQnnnL) begin
    if (!RstQnnnL) state <= IDLE;
    else           state <= stateNext;
  end

  // FSM next state: accept in IDLE, capture read data in RD_WAIT, and hold the response in RSP.
  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (MmioReqReady) stateNext = MmioReqWr ? RSP : RD_WAIT;
      RD_WAIT: stateNext = RSP;
      RSP:     if (MmioRspReady) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Response data: the memory word for reads, and zero for write acks.
  always_ff @(posedge QClk or negedge RstQnnnL) begin
    if (!RstQnnnL)                               rspDataReg <= 32'h0;
    else if (state == RD_WAIT)                   rspDataReg <= MemRdData;
    else if (isIdle && MmioReqReady && MmioReqWr) rspDataReg <= 32'h0;
  end

  assign MmioRspValid = (state == RSP);
  assign MmioRspData  = (state == RSP) ? rspDataReg : 32'h0;

  assign DbgState     = state;
  assign DbgStarveCnt = starveCnt;

endmodule

// File: tb/tb_d_mem_arb.sv
// Directed bench for d_mem_arb. It includes a one-cycle-latency memory model.
module tb_d_mem_arb;

  logic        QClk = 1'b0;
  logic        RstQnnnL;
  logic [31:0] CoreAdrsQ103H, CoreWrDataQ103H;
  logic [3:0]  CoreByteEnQ103H;
  logic        CoreWrQ103H, CoreRdQ103H;
  logic        CoreStallQ103H;
  logic [31:0] CoreRdDataQ104H;
  logic        MmioReqValid, MmioReqReady, MmioReqWr;
  logic [31:0] MmioReqAdrs, MmioReqData;
  logic [3:0]  MmioReqByteEn;
  logic        MmioRspValid, MmioRspReady;
  logic [31:0] MmioRspData;
  logic [31:0] MemAdrs, MemWrData;
  logic [3:0]  MemByteEn;
  logic        MemRd, MemWr;
  logic [31:0] MemRdData = 32'h0;
  logic [1:0]  DbgState;
  logic [3:0]  DbgStarveCnt;

  int assertCount = 0;
  int failCount   = 0;

  logic [31:0] mem [0:255];

  d_mem_arb #(.STARVE_MAX(8), .STARVE_CNT_W(4)) dut (
    .QClk(QClk), .RstQnnnL(RstQnnnL),
    .CoreAdrsQ103H(CoreAdrsQ103H), .CoreWrDataQ103H(CoreWrDataQ103H),
    .CoreByteEnQ103H(CoreByteEnQ103H), .CoreWrQ103H(CoreWrQ103H),
    .CoreRdQ103H(CoreRdQ103H), .CoreStallQ103H(CoreStallQ103H),
    .CoreRdDataQ104H(CoreRdDataQ104H),
    .MmioReqValid(MmioReqValid), .MmioReqReady(MmioReqReady),
    .MmioReqWr(MmioReqWr), .MmioReqAdrs(MmioReqAdrs),
    .MmioReqData(MmioReqData), .MmioReqByteEn(MmioReqByteEn),
    .MmioRspValid(MmioRspValid), .MmioRspReady(MmioRspReady),
    .MmioRspData(MmioRspData),
    .MemAdrs(MemAdrs), .MemWrData(MemWrData), .MemByteEn(MemByteEn),
    .MemRd(MemRd), .MemWr(MemWr), .MemRdData(MemRdData),
    .DbgState(DbgState), .DbgStarveCnt(DbgStarveCnt)
  );

  // Clock.
  always #5 QClk = ~QClk;

  // Memory model: one-cycle read latency, with byte-enabled writes.
  always @(posedge QClk) begin
    if (MemRd) MemRdData <= mem[MemAdrs[9:2]];
    if (MemWr) begin
      for (int b = 0; b < 4; b++)
        if (MemByteEn[b]) mem[MemAdrs[9:2]][8*b +: 8] = MemWrData[8*b +: 8];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge QClk);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[8'h40] = 32'hDEADBEEF;   // 0x100
    mem[8'h10] = 32'h12345678;   // 0x40
    mem[8'h11] = 32'hCAFEF00D;   // 0x44
    mem[8'h20] = 32'hFFFFFFFF;   // 0x80

    RstQnnnL = 1'b0;
    CoreAdrsQ103H = 0; CoreWrDataQ103H = 0; CoreByteEnQ103H = 0;
    CoreWrQ103H = 0; CoreRdQ103H = 0;
    MmioReqValid = 0; MmioReqWr = 0; MmioReqAdrs = 0; MmioReqData = 0;
    MmioReqByteEn = 0; MmioRspReady = 0;

    // Reset state.
    step(); step(); #1;
    chk("rst_ready", 32'(MmioReqReady), 0);
    chk("rst_stall", 32'(CoreStallQ103H), 0);
    chk("rst_rspvalid", 32'(MmioRspValid), 0);
    chk("rst_rspdata", MmioRspData, 0);
    chk("rst_corerd", CoreRdDataQ104H, 0);
    chk("rst_memrd", 32'(MemRd), 0);
    chk("rst_memwr", 32'(MemWr), 0);
    chk("rst_state", 32'(DbgState), 0);
    chk("rst_starve", 32'(DbgStarveCnt), 0);
    step(); RstQnnnL = 1'b1;

    // Core-only read from 0x100.
    step(); CoreRdQ103H = 1; CoreAdrsQ103H = 32'h100; #1;
    chk("core_memrd", 32'(MemRd), 1);
    chk("core_memadrs", MemAdrs, 32'h100);
    chk("core_ready", 32'(MmioReqReady), 0);
    step(); CoreRdQ103H = 0; #1;
    chk("core_rddata", CoreRdDataQ104H, 32'hDEADBEEF);
    chk("core_memrd_off", 32'(MemRd), 0);
    step(); #1;
    chk("core_rddata_clr", CoreRdDataQ104H, 0);

    // MMIO read from 0x40 while the core is idle.
    step(); MmioReqValid = 1; MmioReqWr = 0; MmioReqAdrs = 32'h40; #1;
    chk("mrd_ready", 32'(MmioReqReady), 1);
    chk("mrd_memrd", 32'(MemRd), 1);
    chk("mrd_memadrs", MemAdrs, 32'h40);
    step(); MmioReqValid = 0; #1;
    chk("mrd_state_rdwait", 32'(DbgState), 1);
    chk("mrd_rspvalid_early", 32'(MmioRspValid), 0);
    step(); #1;
    chk("mrd_rspvalid", 32'(MmioRspValid), 1);
    chk("mrd_rspdata", MmioRspData, 32'h12345678);
    step(); MmioRspReady = 1; #1;
    chk("mrd_rspvalid_held", 32'(MmioRspValid), 1);
    chk("mrd_rspdata_held", MmioRspData, 32'h12345678);
    step(); MmioRspReady = 0; #1;
    chk("mrd_rspvalid_done", 32'(MmioRspValid), 0);

    // MMIO write to 0x80: low two bytes only.
    step(); MmioReqValid = 1; MmioReqWr = 1; MmioReqAdrs = 32'h80;
    MmioReqData = 32'hA5A5A5A5; MmioReqByteEn = 4'b0011; MmioRspReady = 1; #1;
    chk("mwr_ready", 32'(MmioReqReady), 1);
    chk("mwr_memwr", 32'(MemWr), 1);
    chk("mwr_memrd", 32'(MemRd), 0);
    chk("mwr_byteen", 32'(MemByteEn), 32'h3);
    chk("mwr_wrdata", MemWrData, 32'hA5A5A5A5);
    step(); MmioReqValid = 0; MmioReqWr = 0; #1;
    chk("mwr_rspvalid", 32'(MmioRspValid), 1);
    chk("mwr_rspdata", MmioRspData, 0);
    step(); MmioRspReady = 0; CoreRdQ103H = 1; CoreAdrsQ103H = 32'h80; #1;
    chk("mwr_rspvalid_done", 32'(MmioRspValid), 0);
    step(); CoreRdQ103H = 0; #1;
    chk("mwr_readback", CoreRdDataQ104H, 32'hFFFFA5A5);

    // Starvation: the core reads continuously while MMIO waits.
    step(); CoreRdQ103H = 1; CoreAdrsQ103H = 32'h100;
    MmioReqValid = 1; MmioReqWr = 0; MmioReqAdrs = 32'h40; MmioRspReady = 1;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk($sformatf("stv_ready_%0d", i), 32'(MmioReqReady), 0);
      chk($sformatf("stv_stall_%0d", i), 32'(CoreStallQ103H), 0);
      chk($sformatf("stv_cnt_%0d", i), 32'(DbgStarveCnt), i);
      step();
    end
    #1;
    chk("stv_hit_stall", 32'(CoreStallQ103H), 1);
    chk("stv_hit_ready", 32'(MmioReqReady), 1);
    chk("stv_hit_memadrs", MemAdrs, 32'h40);
    step(); MmioReqValid = 0; #1;
    chk("stv_cnt_clear", 32'(DbgStarveCnt), 0);
    chk("stv_stall_off", 32'(CoreStallQ103H), 0);
    chk("stv_core_dropped", CoreRdDataQ104H, 0);
    chk("stv_core_resume", MemAdrs, 32'h100);
    step(); CoreRdQ103H = 0; #1;
    chk("stv_rspvalid", 32'(MmioRspValid), 1);
    chk("stv_rspdata", MmioRspData, 32'h12345678);
    chk("stv_core_data", CoreRdDataQ104H, 32'hDEADBEEF);

    // Response backpressure: a second request waits while the core keeps reading.
    step(); MmioRspReady = 0; MmioReqValid = 1; MmioReqAdrs = 32'h40; #1;
    chk("bp_accept", 32'(MmioReqReady), 1);
    step(); MmioReqAdrs = 32'h44; #1;
    chk("bp_rdwait_ready", 32'(MmioReqReady), 0);
    step();
    for (int i = 0; i < 5; i++) begin
      CoreRdQ103H = 1; CoreAdrsQ103H = 32'h100; #1;
      chk($sformatf("bp_ready_%0d", i), 32'(MmioReqReady), 0);
      chk($sformatf("bp_rspvalid_%0d", i), 32'(MmioRspValid), 1);
      chk($sformatf("bp_rspdata_%0d", i), MmioRspData, 32'h12345678);
      chk($sformatf("bp_memrd_%0d", i), 32'(MemRd), 1);
      if (i > 0) chk($sformatf("bp_coredata_%0d", i), CoreRdDataQ104H, 32'hDEADBEEF);
      step();
    end
    CoreRdQ103H = 0; MmioRspReady = 1; #1;
    chk("bp_release_valid", 32'(MmioRspValid), 1);
    chk("bp_release_ready", 32'(MmioReqReady), 0);
    step(); MmioRspReady = 0; #1;
    chk("bp_second_accept", 32'(MmioReqReady), 1);
    chk("bp_second_adrs", MemAdrs, 32'h44);

    // Reset while the second read is in RD_WAIT.
    step(); MmioReqValid = 0; #1;
    chk("rrst_pre_state", 32'(DbgState), 1);
    RstQnnnL = 0; #1;
    chk("rrst_state", 32'(DbgState), 0);
    chk("rrst_rspvalid", 32'(MmioRspValid), 0);
    chk("rrst_starve", 32'(DbgStarveCnt), 0);
    step(); RstQnnnL = 1;
    for (int i = 0; i < 3; i++) begin
      step(); #1;
      chk($sformatf("rrst_norsp_%0d", i), 32'(MmioRspValid), 0);
      chk($sformatf("rrst_idle_%0d", i), 32'(DbgState), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
